// File: rtl/rv_inst_encoder.sv
// -----------------------------------------------------------------------------
// rv_inst_encoder
//   Packs a field-level RV32I instruction description into a 32-bit instruction
//   word. The immediate is checked against the range and alignment that the
//   selected format can represent. An illegal descriptor is emitted as an
//   all-zero word with out_err set.
//   The result sits in a one-deep registered valid/ready stage, tagged with the
//   instruction-memory address taken from an auto-incrementing write pointer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input descriptor handshake
//   opcode, rd, rs1, rs2, funct3, funct7, imm
//                     descriptor fields (imm is the sign-extended
//                     architectural value)
//   addr_load/addr_in reload the write pointer (word aligned)
//   out_valid/out_ready
//                     output handshake
//   out_inst          encoded instruction (0 when illegal)
//   out_addr          memory address for out_inst
//   out_err           descriptor was illegal
//   err_count         saturating count of accepted illegal descriptors
// -----------------------------------------------------------------------------
module rv_inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  input  logic             addr_load,
  input  logic [31:0]      addr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Masks cover the field's sign bit and every bit above it.
  localparam logic [31:0] MASK_I = 32'hFFFF_F800;  // sign bit 11
  localparam logic [31:0] MASK_B = 32'hFFFF_F000;  // sign bit 12
  localparam logic [31:0] MASK_J = 32'hFFF0_0000;  // sign bit 20

  // The value fits when every masked bit equals the sign bit, that is when the
  // masked bits are either all zero or all one.
  function automatic logic imm_fits(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == 32'h0000_0000) || ((v & mask) == mask);
  endfunction

  logic [31:0]      r_out_inst;
  logic [31:0]      r_out_addr;
  logic [31:0]      r_wr_ptr;
  logic             r_out_valid;
  logic             r_out_err;
  logic [CNT_W-1:0] r_err_count;

  logic [31:0]      w_inst;
  logic             w_legal;
  logic             w_accept;
  logic [31:0]      w_addr;
  logic             w_cnt_max;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A load in the accept cycle supplies this word's address.
  assign w_addr    = addr_load ? addr_in : r_wr_ptr;
  assign w_cnt_max = &r_err_count;

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

  // Format selection, field packing and immediate legality
  always_comb begin
    w_inst  = 32'h0000_0000;
    w_legal = 1'b0;
    case (opcode)
      OP_R: begin
        w_inst  = {funct7, rs2, rs1, funct3, rd, opcode};
        w_legal = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_inst  = {imm[11:0], rs1, funct3, rd, opcode};
        w_legal = imm_fits(imm, MASK_I);
      end
      OP_STORE: begin
        w_inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_legal = imm_fits(imm, MASK_I);
      end
      OP_BRANCH: begin
        w_inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_legal = imm_fits(imm, MASK_B) && (imm[0] == 1'b0);
      end
      OP_JAL: begin
        w_inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_legal = imm_fits(imm, MASK_J) && (imm[0] == 1'b0);
      end
      OP_LUI, OP_AUIPC: begin
        w_inst  = {imm[31:12], rd, opcode};
        w_legal = (imm[11:0] == 12'h000);
      end
      default: begin
        w_inst  = 32'h0000_0000;
        w_legal = 1'b0;
      end
    endcase
  end

  // Output stage, write pointer and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= 32'h0000_0000;
      r_out_addr  <= 32'h0000_0000;
      r_out_err   <= 1'b0;
      r_err_count <= '0;
      r_wr_ptr    <= BASE_ADDR;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= w_legal ? w_inst : 32'h0000_0000;
      r_out_err   <= !w_legal;
      r_out_addr  <= w_addr;
      r_wr_ptr    <= w_addr + 32'd4;
      if (!w_legal && !w_cnt_max) begin
        r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_err_count <= r_err_count;
      end
    end else begin
      // Data fields hold after a transfer; only the valid flag drops.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (addr_load) begin
        r_wr_ptr <= addr_in;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
module tb_rv_inst_encoder;

  localparam int CNT_W = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [6:0] opcode = 7'd0;
  logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic addr_load = 1'b0;
  logic [31:0] addr_in = 32'd0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_inst, out_addr;
  logic out_err;
  logic [CNT_W-1:0] err_count;

  rv_inst_encoder #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // expected output state
  logic        m_valid = 1'b0;
  logic [31:0] m_inst = 32'd0, m_addr = 32'd0, m_ptr = BASE;
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  logic [31:0] xfer[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural encoding: legality from signed arithmetic ranges, packing
  // by shifting extracted immediate pieces into place.
  function automatic void model_enc(input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] iv,
      output logic [31:0] w, output bit ok);
    int s;
    logic [31:0] base;
    s = $signed(iv);
    base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    w = 32'd0;
    ok = 0;
    case (op)
      7'h33: begin ok = 1; w = (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7); end
      7'h13, 7'h03, 7'h67: begin
        ok = (s >= -2048) && (s <= 2047);
        w = ((iv & 32'hFFF) << 20) | base | (32'(d) << 7);
      end
      7'h23: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((iv >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((iv & 32'h1F) << 7);
      end
      7'h63: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w = (((iv >> 12) & 32'h1) << 31) | (((iv >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
          | base | (((iv >> 1) & 32'hF) << 8) | (((iv >> 11) & 32'h1) << 7);
      end
      7'h6F: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w = (((iv >> 20) & 32'h1) << 31) | (((iv >> 1) & 32'h3FF) << 21)
          | (((iv >> 11) & 32'h1) << 20) | (((iv >> 12) & 32'hFF) << 12)
          | (32'(d) << 7) | 32'(op);
      end
      7'h37, 7'h17: begin
        ok = (iv % 32'h1000) == 32'd0;
        w = (iv & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      end
      default: ok = 0;
    endcase
    if (!ok) w = 32'd0;
  endfunction

  // Recover the immediate from an encoded word (inverse path).
  function automatic logic [31:0] decode_imm(input logic [31:0] w);
    logic [31:0] r;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: r = 32'($signed(w) >>> 20);
      7'h23: r = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h6F: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: r = w & 32'hFFFF_F000;
    endcase
    return r;
  endfunction

  // One clock: check in_ready, advance the model, then compare all outputs.
  task automatic cycle();
    logic [31:0] enc;
    bit ok;
    #1;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (out_valid && out_ready) xfer.push_back(out_addr);
    end
    if (rst) begin
      m_valid = 0; m_inst = 0; m_addr = 0; m_err = 0; m_cnt = 0; m_ptr = BASE;
    end else if (in_valid && (!m_valid || out_ready)) begin
      model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm, enc, ok);
      m_addr = addr_load ? addr_in : m_ptr;
      m_ptr = m_addr + 32'd4;
      m_valid = 1; m_inst = enc; m_err = !ok;
      if (!ok && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if (addr_load) m_ptr = addr_in;
    end
    @(posedge clk);
    #2;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_inst", out_inst, m_inst);
    chk("out_addr", out_addr, m_addr);
    chk("out_err", 32'(out_err), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic desc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] iv);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'd0; imm = iv;
  endtask

  initial begin
    logic [31:0] held;
    int fmt;
    logic [31:0] iv;
    logic [6:0] op;

    rst = 1'b1; cycle(); cycle();
    rst = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_addr", out_addr, 32'd0);
    chk("reset_cnt", 32'(err_count), 32'd0);

    // ADDI x5, x0, -1
    in_valid = 1'b1; out_ready = 1'b1;
    desc(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF); cycle();
    chk("addi_inst", out_inst, 32'hFFF0_0293);
    chk("addi_addr", out_addr, 32'h0);
    chk("addi_err", 32'(out_err), 32'd0);

    // BEQ x1, x2: -8, then out of range 4096, then 6
    desc(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8); cycle();
    chk("beq_inst", out_inst, 32'hFE20_8CE3);
    chk("beq_addr", out_addr, 32'h4);
    imm = 32'd4096; cycle();
    chk("beq_range_err", 32'(out_err), 32'd1);
    chk("beq_range_inst", out_inst, 32'h0);
    chk("beq_range_cnt", 32'(err_count), 32'd1);
    imm = 32'd6; cycle();
    chk("beq6_err", 32'(out_err), 32'd0);
    chk("beq6_inst", out_inst, 32'h0020_8363);

    // JAL, LUI, misaligned LUI
    desc(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048); cycle();
    chk("jal_inst", out_inst, 32'h0010_00EF);
    desc(7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_5000); cycle();
    chk("lui_inst", out_inst, 32'h1234_51B7);
    imm = 32'h1234_5001; cycle();
    chk("lui_bad_err", 32'(out_err), 32'd1);
    chk("lui_bad_cnt", 32'(err_count), 32'd2);
    in_valid = 1'b0; cycle();

    // Backpressure: four words, output stalled for three cycles
    rst = 1'b1; cycle(); rst = 1'b0;
    xfer.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    desc(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1); cycle();
    held = out_inst;
    desc(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold", out_inst, held);
    end
    out_ready = 1'b1; cycle();
    desc(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3); cycle();
    desc(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 32'd4); cycle();
    in_valid = 1'b0; cycle(); cycle();
    chk("bp_count", 32'(xfer.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < xfer.size()) chk("bp_addr", xfer[i], 32'(i * 4));
    end

    // Address load together with accept, then wrap at the top of memory
    in_valid = 1'b1; addr_load = 1'b1; addr_in = 32'h100; cycle();
    chk("load_accept_addr", out_addr, 32'h100);
    addr_load = 1'b0; cycle();
    chk("load_next_addr", out_addr, 32'h104);
    in_valid = 1'b0; addr_load = 1'b1; addr_in = 32'hFFFF_FFFC; cycle();
    addr_load = 1'b0; in_valid = 1'b1; cycle();
    chk("top_addr", out_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr", out_addr, 32'h0);

    // Saturating error count
    desc(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    for (int i = 0; i < 300; i++) cycle();
    chk("sat_cnt", 32'(err_count), 32'd255);

    // Reset while stalled
    desc(7'b0010011, 5'd7, 5'd1, 5'd0, 3'd0, 32'd5);
    out_ready = 1'b0; cycle(); cycle();
    rst = 1'b1; cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    rst = 1'b0; out_ready = 1'b1; cycle();
    chk("rst_next_addr", out_addr, BASE);

    // Random legal descriptors, decoded back to the immediate
    for (int i = 0; i < 40; i++) begin
      fmt = $urandom_range(0, 4);
      case (fmt)
        0: begin op = 7'b0010011; iv = 32'($urandom_range(0, 4095)) - 32'd2048; end
        1: begin op = 7'b0100011; iv = 32'($urandom_range(0, 4095)) - 32'd2048; end
        2: begin op = 7'b1100011; iv = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
        3: begin op = 7'b1101111; iv = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1; end
        default: begin op = 7'b0110111; iv = $urandom() & 32'hFFFF_F000; end
      endcase
      desc(op, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()), iv);
      cycle();
      chk("rand_err", 32'(out_err), 32'd0);
      chk("rand_op", 32'(out_inst[6:0]), 32'(op));
      chk("rand_imm", decode_imm(out_inst), iv);
    end
    in_valid = 1'b0; cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
